// File: rtl/if_pkg.sv
// Shared types and constants for the IF/ID fetch queue.
package if_pkg;

    localparam int          FQ_WIDTH = 32;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;   // addi x0,x0,0

    typedef struct packed {
        logic [FQ_WIDTH-1:0] pc;
        logic [FQ_WIDTH-1:0] inst;
    } fq_entry_t;

    function automatic bit is_pow2_ge2(int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/if_fetch_queue.sv
// Multi-entry IF/ID decoupling queue: buffers {pc, inst} pairs so fetch can run
// ahead while decode stalls; an empty or flushed queue shows a NOP bubble to ID.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int                 WIDTH    = FQ_WIDTH,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   NOP_INST = WIDTH'(if_pkg::NOP_INST),
    localparam int                CW       = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             IF_valid,
    input  logic [WIDTH-1:0] IF_pc,
    input  logic [WIDTH-1:0] IF_inst,
    output logic             IF_ready,
    input  logic             ID_stall,
    input  logic             ID_flush,
    output logic             ID_valid,
    output logic [WIDTH-1:0] ID_pc,
    output logic [WIDTH-1:0] ID_inst,
    output logic [CW-1:0]    o_count
);

    localparam int PW = $clog2(DEPTH);

    generate
        if (!is_pow2_ge2(DEPTH)) begin : g_bad_depth
            $error("if_fetch_queue: DEPTH must be a power of two and >= 2");
        end
    endgenerate

    // Same layout as if_pkg::fq_entry_t, sized by WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] inst;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            push, pop;

    // Ready looks only at registered count, so a full queue refuses a push
    // even when the head pops in the same cycle.
    assign IF_ready = (count_q != CW'(DEPTH));
    assign push     = IF_valid & IF_ready;
    assign pop      = ID_valid & ~ID_stall;
    assign o_count  = count_q;

    always_comb begin
        ID_valid = 1'b0;
        ID_pc    = '0;
        ID_inst  = NOP_INST;
        if (count_q != '0) begin
            ID_valid = 1'b1;
            ID_pc    = mem_q[rd_ptr_q].pc;
            ID_inst  = mem_q[rd_ptr_q].inst;
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (ID_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; count gates everything read from it.
    always_ff @(posedge i_clk) begin
        if (push && !ID_flush) begin
            mem_q[wr_ptr_q] <= '{pc: IF_pc, inst: IF_inst};
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue (DEPTH=4, WIDTH=32) with hand-computed expectations.
module tb_if_fetch_queue;
    import if_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             IF_valid;
    logic [WIDTH-1:0] IF_pc;
    logic [WIDTH-1:0] IF_inst;
    logic             IF_ready;
    logic             ID_stall;
    logic             ID_flush;
    logic             ID_valid;
    logic [WIDTH-1:0] ID_pc;
    logic [WIDTH-1:0] ID_inst;
    logic [CW-1:0]    o_count;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .IF_valid (IF_valid),
        .IF_pc    (IF_pc),
        .IF_inst  (IF_inst),
        .IF_ready (IF_ready),
        .ID_stall (ID_stall),
        .ID_flush (ID_flush),
        .ID_valid (ID_valid),
        .ID_pc    (ID_pc),
        .ID_inst  (ID_inst),
        .o_count  (o_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] inst);
        IF_valid = v;
        IF_pc    = pc;
        IF_inst  = inst;
    endtask

    always @(negedge i_clk) begin
        if (i_rst === 1'b0) chk("count_bound", 64'(o_count <= CW'(DEPTH)), 64'd1);
    end

    initial begin
        fq_entry_t exp_head;

        i_rst    = 1'b1;
        ID_stall = 1'b0;
        ID_flush = 1'b0;
        drive(1'b0, '0, '0);
        tick();
        tick();
        i_rst = 1'b0;
        tick();

        // 1: reset / idle
        chk("rst_valid", ID_valid, 0);
        chk("rst_inst",  ID_inst,  32'h13);
        chk("rst_pc",    ID_pc,    0);
        chk("rst_ready", IF_ready, 1);
        chk("rst_count", o_count,  0);

        // 2: single push, one-cycle latency, then drained
        drive(1'b1, 32'h100, 32'hAAAA_0001);
        tick();
        drive(1'b0, '0, '0);
        exp_head = '{pc: 32'h100, inst: 32'hAAAA_0001};
        chk("t2_valid", ID_valid, 1);
        chk("t2_pc",    ID_pc,    exp_head.pc);
        chk("t2_inst",  ID_inst,  exp_head.inst);
        tick();
        chk("t2_drain_valid", ID_valid, 0);
        chk("t2_drain_inst",  ID_inst,  32'h13);
        chk("t2_drain_count", o_count,  0);

        // 3: stall and fill
        ID_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, WIDTH'(4 * i), WIDTH'(32'hB000_0000 + i));
            tick();
        end
        drive(1'b1, 32'h10, 32'hB000_0004);
        chk("t3_count", o_count,  4);
        chk("t3_ready", IF_ready, 0);
        chk("t3_head",  ID_pc,    0);
        tick();
        chk("t3_held_count", o_count, 4);
        chk("t3_held_head",  ID_pc,   0);

        // 4: release; full queue refuses push in the popping cycle
        ID_stall = 1'b0;
        chk("t4_c0_pc",    ID_pc,    32'h0);
        chk("t4_c0_ready", IF_ready, 0);
        tick();
        chk("t4_c1_pc",    ID_pc,    32'h4);
        chk("t4_c1_inst",  ID_inst,  32'hB000_0001);
        chk("t4_c1_ready", IF_ready, 1);
        chk("t4_c1_count", o_count,  3);
        tick();
        drive(1'b0, '0, '0);
        chk("t4_c2_pc",    ID_pc,   32'h8);
        chk("t4_c2_count", o_count, 3);
        tick();
        chk("t4_c3_pc",    ID_pc,   32'hC);
        chk("t4_c3_count", o_count, 2);
        tick();
        chk("t4_c4_pc",    ID_pc,   32'h10);
        chk("t4_c4_inst",  ID_inst, 32'hB000_0004);
        chk("t4_c4_count", o_count, 1);
        tick();
        chk("t4_empty_valid", ID_valid, 0);
        chk("t4_empty_count", o_count,  0);

        // 5: flush with stall and a same-cycle push
        ID_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, WIDTH'(32'h20 + 4 * i), WIDTH'(32'hC000_0000 + i));
            tick();
        end
        chk("t5_pre_count", o_count, 3);
        ID_flush = 1'b1;
        drive(1'b1, 32'h2C, 32'hC000_0003);
        tick();
        ID_flush = 1'b0;
        drive(1'b0, '0, '0);
        chk("t5_count", o_count,  0);
        chk("t5_valid", ID_valid, 0);
        chk("t5_inst",  ID_inst,  32'h13);
        chk("t5_pc",    ID_pc,    0);
        ID_stall = 1'b0;
        drive(1'b1, 32'h30, 32'hC000_0010);
        tick();
        drive(1'b0, '0, '0);
        chk("t5_after_pc",    ID_pc,   32'h30);
        chk("t5_after_count", o_count, 1);
        tick();
        chk("t5_after_drain", o_count, 0);

        // 6: async reset between edges
        ID_stall = 1'b1;
        drive(1'b1, 32'h40, 32'hD000_0000);
        tick();
        drive(1'b1, 32'h44, 32'hD000_0001);
        tick();
        drive(1'b0, '0, '0);
        chk("t6_pre_count", o_count, 2);
        #2 i_rst = 1'b1;
        #1;
        chk("t6_async_valid", ID_valid, 0);
        chk("t6_async_count", o_count,  0);
        chk("t6_async_ready", IF_ready, 1);
        i_rst = 1'b0;
        ID_stall = 1'b0;
        tick();
        drive(1'b1, 32'h50, 32'hD000_0010);
        tick();
        drive(1'b0, '0, '0);
        chk("t6_resume_pc",    ID_pc,   32'h50);
        chk("t6_resume_inst",  ID_inst, 32'hD000_0010);
        chk("t6_resume_count", o_count, 1);
        tick();
        chk("t6_resume_drain", ID_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised multi-entry IF/ID decoupling queue: a successor to the single-register IF/ID stage.
- Buffers up to DEPTH fetched {pc, inst} pairs, so IF keeps fetching while ID stalls.
- Provides valid/ready handshake on the fetch side, and stall/flush control plus a valid flag on the decode side.
- Sits between the fetch unit and the decode stage; an empty or flushed queue presents a NOP bubble to ID.

Parameters:
- WIDTH, 32, width of pc and instruction fields.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- NOP_INST, 32'h0000_0013, instruction word presented to ID when no valid entry exists (addi x0,x0,0).
- CW, $clog2(DEPTH)+1, derived; width of occupancy count.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- IF_valid  in  1  fetch presents a valid {IF_pc, IF_inst}.
- IF_pc  in  WIDTH  fetched pc.
- IF_inst  in  WIDTH  fetched instruction.
- IF_ready  out  1  queue can accept a push this cycle.
- ID_stall  in  1  decode cannot consume the head this cycle.
- ID_flush  in  1  discard all queued entries (branch/jump redirect).
- ID_valid  out  1  head entry is valid.
- ID_pc  out  WIDTH  head pc; 0 when ID_valid=0.
- ID_inst  out  WIDTH  head instruction; NOP_INST when ID_valid=0.
- o_count  out  CW  current occupancy, 0..DEPTH.

Behaviour:
- Reset (i_rst=1, async):
  - rd/wr pointers=0, count=0.
  - Outputs: ID_valid=0, ID_pc=0, ID_inst=NOP_INST, IF_ready=1, o_count=0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all entries immediately, without waiting for a clock edge.
- Push = IF_valid & IF_ready. Pop = ID_valid & ~ID_stall.
- IF_ready = (count != DEPTH). It depends only on registered state, with no combinational path from ID_stall.
  - Consequence: a full queue refuses a push even when a pop occurs in the same cycle.
- Head outputs are driven combinationally from registered storage at rd_ptr, gated by count != 0.
- Latency: data pushed at edge N is visible on ID_* after edge N (1 cycle), when the queue was empty before the push.
- Simultaneous push and pop (count between 1 and DEPTH-1): both occur; count unchanged; both pointers advance.
- Push with no pop: write entry at wr_ptr, wr_ptr+1, count+1.
- Pop with no push: rd_ptr+1, count-1.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH naturally. Count is held separately to disambiguate full from empty.
- Flush (ID_flush=1 at an edge) has highest synchronous priority:
  - count=0, rd_ptr=wr_ptr=0.
  - Any push or pop in the same cycle is dropped.
  - From the next cycle: ID_valid=0, ID_pc=0, ID_inst=NOP_INST.
- Flush together with stall: flush wins.
- Stall with count=0: no effect.
- Pop and stall are irrelevant while ID_valid=0.
- Overflow and underflow are impossible by construction. The bench asserts count never exceeds DEPTH.
- DEPTH=1 is not supported; elaboration fails on a non-power-of-two DEPTH or DEPTH<2.

Decomposition:
- Shared package (if_pkg):
  - Typedef fq_entry_t {logic [WIDTH-1:0] pc; logic [WIDTH-1:0] inst;}.
  - Constant NOP_INST.
- No sub-module. Storage array, pointer logic and count live in one module; total RTL is about 150 lines.

Test Plan:
1. Reset then idle -> ID_valid=0, ID_inst=32'h13, ID_pc=0, IF_ready=1, o_count=0.
2. Push pc=0x100/inst=0xAAAA_0001 with ID_stall=0 -> next cycle ID_valid=1, ID_pc=0x100; one cycle later, with no further push, ID_valid=0.
3. ID_stall=1, push 5 entries pc=0x0,0x4,0x8,0xC,0x10 -> after 4 pushes o_count=4 and IF_ready=0; the 5th is held by IF; ID_pc stays 0x0.
4. Full queue, release stall and keep IF_valid=1 -> entries pop in order 0x0,0x4,0x8,0xC,0x10 with no loss or duplication; pointer wrap is exercised.
5. Queue holding 3 entries, ID_flush=1 with IF_valid=1 in the same cycle -> next cycle o_count=0, ID_valid=0, ID_inst=32'h13; the flushed-cycle push is absent.
6. Assert i_rst asynchronously between edges with count=2 -> ID_valid and o_count drop to 0 before the next edge; after release, normal push resumes.
